// File: rtl/seq_detect_sched.sv
// seq_detect_sched
//   Two-requester round-robin frame scheduler feeding a serial "00/11"
//   detector. A granted FRAME_W-bit frame is shifted out MSB first on Ser_w;
//   Match flags every bit that equals the previous bit of the same frame, and
//   the number of such bits is reported on Count when the frame completes.
//
// Parameters
//   FRAME_W  bits per frame (2..16)
//
// Ports
//   Clk          clock, rising edge
//   Rst          asynchronous reset, active low
//   Req0/Req1    requester has a frame pending
//   Data0/Data1  requester frame, captured at the grant edge
//   Gnt0/Gnt1    one-cycle grant pulse (combinational, IDLE only)
//   Busy         frame in progress (SHIFT or DONE)
//   Ser_w        serial bit presented to the detector
//   Match        current bit equals previous bit of this frame
//   Done         one-cycle frame-complete pulse
//   Count        Match count of the last completed frame
//   Src          requester owning the current or last frame
module seq_detect_sched #(
    parameter int FRAME_W = 8
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Req0,
    input  logic [FRAME_W-1:0] Data0,
    input  logic               Req1,
    input  logic [FRAME_W-1:0] Data1,
    output logic               Gnt0,
    output logic               Gnt1,
    output logic               Busy,
    output logic               Ser_w,
    output logic               Match,
    output logic               Done,
    output logic [3:0]         Count,
    output logic               Src
);

    localparam int IDX_W = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [FRAME_W-1:0] shreg_q;
    logic [IDX_W-1:0]   idx_q;
    logic               prev_q;
    logic               last_gnt_q;   // 1: requester 1 was granted last
    logic               grant_any;
    logic               grant_sel;    // 1: requester 1 wins this grant

    always_comb begin
        state_d   = state_q;
        Gnt0      = 1'b0;
        Gnt1      = 1'b0;
        Busy      = 1'b0;
        Ser_w     = 1'b0;
        Match     = 1'b0;
        Done      = 1'b0;
        grant_any = 1'b0;
        grant_sel = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Rst gating keeps the grants low while reset is held,
                // since they are otherwise a direct function of Req.
                if (Rst && (Req0 || Req1)) begin
                    grant_any = 1'b1;
                    grant_sel = Req1 && (!Req0 || !last_gnt_q);
                    Gnt0      = !grant_sel;
                    Gnt1      = grant_sel;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                Busy  = 1'b1;
                Ser_w = shreg_q[FRAME_W-1];
                Match = (idx_q != '0) && (Ser_w == prev_q);
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                Busy    = 1'b1;
                Done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            idx_q      <= '0;
            prev_q     <= 1'b0;
            Count      <= '0;
            Src        <= 1'b0;
            last_gnt_q <= 1'b1;
        end else begin
            state_q <= state_d;
            if (grant_any) begin
                shreg_q    <= grant_sel ? Data1 : Data0;
                Src        <= grant_sel;
                last_gnt_q <= grant_sel;
                idx_q      <= '0;
                Count      <= '0;
                prev_q     <= 1'b0;
            end else if (state_q == SHIFT) begin
                shreg_q <= {shreg_q[FRAME_W-2:0], 1'b0};
                idx_q   <= idx_q + 1'b1;
                prev_q  <= Ser_w;
                if (Match) begin
                    Count <= Count + 4'd1;
                end
            end
        end
    end

endmodule

// File: doc/seq_detect_sched.md
SEQ_DETECT_SCHED -- requirements
Module: seq_detect_sched

Interface
REQ-001 The block SHALL have parameter FRAME_W, default 8, meaning the number of bits serialised per frame (legal range 2..16).
REQ-002 The block SHALL have port Clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port Rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port Req0, input, 1 bit: requester 0 has a frame pending.
REQ-005 The block SHALL have port Data0, input, FRAME_W bits: requester 0 frame, sampled on grant.
REQ-006 The block SHALL have port Req1, input, 1 bit: requester 1 has a frame pending.
REQ-007 The block SHALL have port Data1, input, FRAME_W bits: requester 1 frame, sampled on grant.
REQ-008 The block SHALL have port Gnt0, output, 1 bit: one-cycle grant/accept pulse to requester 0.
REQ-009 The block SHALL have port Gnt1, output, 1 bit: one-cycle grant/accept pulse to requester 1.
REQ-010 The block SHALL have port Busy, output, 1 bit: a frame is in progress.
REQ-011 The block SHALL have port Ser_w, output, 1 bit: the serial bit currently presented to the 00/11 detector.
REQ-012 The block SHALL have port Match, output, 1 bit: detector z; the current bit equals the previous bit of the same frame.
REQ-013 The block SHALL have port Done, output, 1 bit: one-cycle pulse marking frame completion.
REQ-014 The block SHALL have port Count, output, 4 bits: number of Match cycles in the last completed frame.
REQ-015 The block SHALL have port Src, output, 1 bit: index of the requester owning the current or last frame.

Function
REQ-016 The block SHALL implement the FSM states IDLE, SHIFT and DONE.
REQ-017 In IDLE, when at least one Req is high, the block SHALL assert exactly one Gnt combinationally in that cycle and move to SHIFT at the next edge.
REQ-018 At that same edge the block SHALL capture the granted Data into the shift register, set Src, clear the bit index, clear Count and clear the detector history.
REQ-019 If both Req are high in IDLE, the block SHALL grant the requester not granted last (round-robin), with the last-grant register resetting so that requester 0 wins first.
REQ-020 In SHIFT, Ser_w SHALL present the shift register MSB; the register shifts left by one at each edge, and the bit index increments.
REQ-021 In SHIFT, Match SHALL equal (bit index != 0) AND (Ser_w == previous bit); the previous-bit register loads Ser_w at each edge.
REQ-022 At each SHIFT edge where Match is high, Count SHALL increment; the maximum is FRAME_W-1, so no wrap occurs.
REQ-023 After FRAME_W SHIFT cycles the FSM SHALL go to DONE; Done SHALL be high for exactly that one cycle, and the FSM then returns to IDLE.
REQ-024 Done SHALL occur exactly FRAME_W+1 cycles after the Gnt cycle.
REQ-025 Busy SHALL be high in SHIFT and DONE and low in IDLE.
REQ-026 Req inputs SHALL be ignored while Busy is high; no Gnt is issued outside IDLE.
REQ-027 Count and Src SHALL hold their values from DONE until the next grant edge.
REQ-028 Ser_w and Match SHALL be 0 outside SHIFT.
REQ-029 A requester holding Req continuously SHALL receive back-to-back frames with exactly one IDLE cycle between Done and the next Gnt.

Reset
REQ-030 While Rst is low, the block SHALL immediately set the FSM to IDLE and drive Gnt0=0, Gnt1=0, Busy=0, Ser_w=0, Match=0, Done=0, Count=0 and Src=0, with the last-grant register set so that requester 0 wins next.
REQ-031 A reset asserted mid-frame SHALL abort the frame with no Done pulse; normal operation resumes from IDLE on the first edge after Rst rises.

Verification
REQ-032 The bench SHALL cover: Req0=1, Data0=8'b11001100 -> Ser_w sequence 1,1,0,0,1,1,0,0; Match on bit indices 1,3,5,7; Done 9 cycles after Gnt0 with Count=4 and Src=0.
REQ-033 The bench SHALL cover: Req1=1, Data1=8'b10101010 -> Match never asserts; Done with Count=0 and Src=1.
REQ-034 The bench SHALL cover: Data0=8'b00000000 -> Match on indices 1..7; Count=7. Also Data0=8'hFF -> Count=7.
REQ-035 The bench SHALL cover: Req0 and Req1 both held from reset -> grant order Gnt0, Gnt1, Gnt0, Gnt1, each Gnt exactly 10 cycles apart, and Src alternating 0,1,0,1.
REQ-036 The bench SHALL cover: Rst driven low during the 4th SHIFT cycle -> all outputs 0 without waiting for a clock edge, no Done pulse; after release with Req0=1 -> Gnt0 on the first IDLE cycle.
REQ-037 The bench SHALL cover: Req1 pulsed while Busy=1 from a requester-0 frame and dropped before Done -> no Gnt1 is issued and Count is unaffected.
